// File: rtl/relu_maxpool_stage.sv
// ReLU followed by 2x2 / stride-2 max pooling over a raster-order sample stream.
// A single output register holds each pooled value; input is back-pressured while it waits.
module relu_maxpool_stage #(
   parameter int DATA_W = 16,
   parameter int FMAP_W = 4,
   parameter int FMAP_H = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_done
);

   localparam int CW = (FMAP_W > 2) ? $clog2(FMAP_W) : 1;
   localparam int RW = (FMAP_H > 2) ? $clog2(FMAP_H) : 1;
   localparam int BN = FMAP_W / 2;
   localparam int BW = (BN > 1) ? $clog2(BN) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(FMAP_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(FMAP_H - 1);

   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [DATA_W-1:0] hreg_q, hreg_d;
   logic [DATA_W-1:0] buf_q [BN];
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              frame_done_q, frame_done_d;

   logic              accept_s;
   logic              buf_we_s;
   logic [BW-1:0]     bidx_s;
   logic [DATA_W-1:0] r_s;
   logic [DATA_W-1:0] buf_wd_s;
   logic [DATA_W-1:0] buf_rd_s;

   function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      max2 = (a > b) ? a : b;
   endfunction

   assign in_ready   = !clr && (!out_valid_q || out_ready);
   assign accept_s   = in_valid && in_ready;
   assign bidx_s     = BW'(col_q >> 1);
   assign buf_rd_s   = buf_q[bidx_s];
   assign r_s        = in_data[DATA_W-1] ? '0 : in_data;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;

   // Next-state: position counters, partial maxima and the output register.
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      hreg_d       = hreg_q;
      buf_we_s     = 1'b0;
      buf_wd_s     = max2(hreg_q, r_s);
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      frame_done_d = 1'b0;
      if (clr) begin
         col_d       = '0;
         row_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = out_valid_q;
         end
         if (accept_s) begin
            case ({row_q[0], col_q[0]})
               2'b00:   hreg_d = r_s;
               2'b01:   buf_we_s = 1'b1;
               2'b10:   hreg_d = r_s;
               2'b11: begin
                  // A completing window overrides the transfer-clear above.
                  out_data_d   = max2(buf_rd_s, max2(hreg_q, r_s));
                  out_valid_d  = 1'b1;
                  frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
               end
               default: hreg_d = hreg_q;
            endcase
            if (col_q == COL_LAST) begin
               col_d = '0;
               row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end else begin
            col_d = col_q;
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         hreg_q       <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < BN; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hreg_q       <= hreg_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         if (buf_we_s) begin
            buf_q[bidx_s] <= buf_wd_s;
         end
      end
   end

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// Directed bench for relu_maxpool_stage: an independent window model feeds a scoreboard queue.
module tb_relu_maxpool_stage;
   localparam int DW = 16;
   localparam int W  = 4;
   localparam int H  = 4;

   logic          clk = 1'b0;
   logic          rst_n, clr, in_valid, in_ready, out_valid, out_ready, frame_done;
   logic [DW-1:0] in_data, out_data;

   always #5 clk = ~clk;

   relu_maxpool_stage #(.DATA_W(DW), .FMAP_W(W), .FMAP_H(H)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .frame_done(frame_done)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_q[$];
   int   cur_frame[16];
   int   m_row, m_col, fd_seen;
   logic exp_ov, exp_fd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int relu(input int v);
      return (v < 0) ? 0 : v;
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = relu(a);
      if (relu(b) > m) m = relu(b);
      if (relu(c) > m) m = relu(c);
      if (relu(d) > m) m = relu(d);
      return m;
   endfunction

   task automatic model_reset();
      m_row  = 0;
      m_col  = 0;
      exp_ov = 1'b0;
      exp_fd = 1'b0;
   endtask

   // One clock: check handshake at negedge, update model, check outputs after posedge.
   task automatic tick(output bit acc);
      logic exp_rdy;
      int   r, c;
      @(negedge clk);
      exp_rdy = !clr && (!exp_ov || out_ready);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("spurious_output", {31'd0, out_valid}, 32'd0);
         else chk("out_data", {16'd0, out_data}, exp_q.pop_front());
      end
      acc = in_valid && exp_rdy;
      if (clr) begin
         model_reset();
         exp_q.delete();
      end else begin
         r = m_row;
         c = m_col;
         exp_fd = 1'b0;
         if (acc && (r % 2 == 1) && (c % 2 == 1)) begin
            exp_q.push_back(max4(cur_frame[(r-1)*W+c-1], cur_frame[(r-1)*W+c],
                                 cur_frame[r*W+c-1], cur_frame[r*W+c]));
            exp_ov = 1'b1;
            exp_fd = (r == H-1) && (c == W-1);
         end else if (out_ready) begin
            exp_ov = 1'b0;
         end
         if (acc) begin
            if (m_col == W-1) begin
               m_col = 0;
               m_row = (m_row == H-1) ? 0 : m_row + 1;
            end else begin
               m_col = m_col + 1;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
      if (frame_done) fd_seen++;
   endtask

   task automatic send(input int v);
      bit acc;
      in_data  = v[DW-1:0];
      in_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         tick(acc);
         if (acc) return;
      end
      n_tests++;
      n_fail++;
      $error("FAIL accept_timeout: observed no accept expected accept of %0d", v);
   endtask

   task automatic send_range(input int first, input int last);
      for (int i = first; i <= last; i++) send(cur_frame[i]);
   endtask

   task automatic idle(input int n);
      bit acc;
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) tick(acc);
   endtask

   task automatic set_ramp(input bit up);
      for (int i = 0; i < 16; i++) cur_frame[i] = up ? i + 1 : 16 - i;
   endtask

   initial begin
      bit acc;
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      fd_seen = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {16'd0, out_data}, 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      rst_n = 1'b1;

      // 1: ramp, continuous flow
      set_ramp(1'b1);
      send_range(0, 15);
      idle(3);

      // 2: all negative
      for (int i = 0; i < 16; i++) cur_frame[i] = -5;
      send_range(0, 15);
      idle(3);

      // 3: stall on first output
      set_ramp(1'b1);
      send_range(0, 5);
      out_ready = 1'b0;
      in_data   = 16'd7;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(acc);
         chk("stall_data", {16'd0, out_data}, 32'd6);
      end
      out_ready = 1'b1;
      send_range(6, 15);
      idle(3);

      // 4: extreme values
      for (int i = 0; i < 16; i++) cur_frame[i] = 0;
      cur_frame[0] = 32767; cur_frame[1] = -32768; cur_frame[4] = -1; cur_frame[5] = 0;
      send_range(0, 15);
      idle(3);
      cur_frame[0] = -32768; cur_frame[1] = -32768; cur_frame[4] = -32768; cur_frame[5] = 1;
      send_range(0, 15);
      idle(3);

      // 5: asynchronous reset mid-frame
      set_ramp(1'b1);
      send_range(0, 6);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_out_data", {16'd0, out_data}, 32'd0);
      chk("midrst_pending", exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      send_range(0, 15);
      idle(3);

      // 6: synchronous clear mid-frame
      send_range(0, 8);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'd10;
      tick(acc);
      chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
      clr = 1'b0;
      send_range(0, 15);
      idle(3);

      // 7: back-to-back frames
      fd_seen = 0;
      send_range(0, 15);
      set_ramp(1'b0);
      send_range(0, 15);
      idle(4);
      chk("frame_done_count", fd_seen, 32'd2);
      chk("all_outputs_seen", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
